serial_sub_ctrl: RTL
====================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial subtract controller. Computes A - B - bin over WIDTH bits using a single 1-bit full-subtract cell.
//  The cell is time-shared across all bit positions, LSB first, with a registered borrow chain.
//  Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake.
//  Sits between operand sources and consumers wherever area matters more than latency.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 1..64
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a_in/b_in/bin are presented
//  in_ready   out  1      controller can accept operands
//  a_in       in   WIDTH  minuend
//  b_in       in   WIDTH  subtrahend
//  bin        in   1      initial borrow-in
//  out_valid  out  1      diff_out/bout hold a completed result
//  out_ready  in   1      consumer accepts the result
//  diff_out   out  WIDTH  (A - B - bin) mod 2^WIDTH
//  bout       out  1      final borrow-out; 1 iff A < B + bin (unsigned)
//  ovf        out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  Reset (async, while rst=1): state=IDLE, bit counter=0, borrow reg=0, shift regs=0,
//   out_valid=0, diff_out=0, bout=0, ovf=0, in_ready=0.
//  FSM states:
//   IDLE: in_ready=1 (combinational: state==IDLE && !rst). On in_valid&in_ready edge:
//    load a/b shift regs, borrow reg<=bin, cnt<=0, go SHIFT.
//   SHIFT: each edge, the cell takes a_sr[0], b_sr[0], borrow and produces d, bo. Then:
//    shift d into diff reg MSB-side (result right-shift), borrow<=bo, shift a_sr/b_sr right, cnt++.
//    On the edge with cnt==WIDTH-1: go DONE, set out_valid=1, bout<=bo.
//   DONE: out_valid=1; diff_out/bout/ovf held stable. On out_valid&out_ready edge: out_valid<=0, go IDLE.
//  Latency: out_valid rises exactly WIDTH clocks after the input-accept edge.
//   Throughput: one op per WIDTH+2 clocks when out_ready=1.
//  in_ready=0 in SHIFT and DONE. in_valid there is ignored; it is neither latched nor queued.
//  in_ready is not asserted in DONE even if out_ready=1. The next accept occurs no earlier than the cycle after DONE->IDLE.
//  WIDTH=1: SHIFT lasts one edge. cnt width is max(1,$clog2(WIDTH)).
//  diff_out is driven only from the result register. Its value in IDLE/SHIFT is don't-care to the consumer but must not be X after reset.
//  A rst assertion mid-SHIFT or mid-DONE aborts the operation immediately. The partial result is discarded and never presented.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//   ovf = borrow into MSB XOR borrow out of MSB, captured on the final SHIFT edge and held with diff_out.
//  SERIAL_SUB_OVF_EN undefined:
//   ovf port and its register are absent. All other behaviour is identical.
// STRUCTURE
//  Package serial_sub_pkg: state_t enum {IDLE, SHIFT, DONE} (2-bit); localparam function cnt_w(WIDTH).
//  Sub-module fs_bit_cell: combinational 1-bit full subtractor.
//   Ports: a, b, bi -> d = a^b^bi, bo = (~a&b) | (~(a^b)&bi).
//   Instantiated exactly once.
//  Top holds the FSM, counter, shift registers and borrow register.
// TESTING (WIDTH=8 unless noted)
//  1. a=0x05 b=0x03 bin=0 -> diff_out=0x02, bout=0, out_valid high exactly 8 clocks after accept.
//  2. a=0x00 b=0x01 bin=0 -> diff_out=0xFF, bout=1. Then a=0x10 b=0x10 bin=1 -> 0xFF, bout=1.
//  3. With SERIAL_SUB_OVF_EN: a=0x80 b=0x01 bin=0 -> diff_out=0x7F, bout=0, ovf=1.
//     a=0x7F b=0xFF bin=0 -> 0x80, bout=1, ovf=1. a=0x05 b=0x03 -> ovf=0.
//  4. Backpressure: hold out_ready=0 for 5 clocks in DONE -> out_valid/diff_out/bout stable, in_ready=0.
//     A new in_valid pulse during this time is ignored; first result unchanged after release.
//  5. Assert rst mid-SHIFT (after 3 bits) -> out_valid=0 and in_ready=0 immediately; in_ready=1 first cycle after release.
//     Next op a=0xAA b=0x55 bin=0 -> 0x55, bout=0.
//  6. WIDTH=1 build: a=0 b=1 bin=1 -> diff_out=0, bout=1, out_valid 1 clock after accept.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtract controller.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be at least 1 bit wide, even for WIDTH=1.
  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bi.
// Ports: a, b, bi in; d difference, bo borrow-out.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - bin, LSB first, one shared subtract cell.
// Ports: clk, rst (async high), in_valid/in_ready + a_in/b_in/bin,
//   out_valid/out_ready + diff_out/bout; ovf with SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] dmsb;

  fs_bit_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .bi (bor_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    // New difference bit enters at the MSB; the register shifts right.
    dmsb           = '0;
    dmsb[WIDTH-1]  = cell_d;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          bor_d   = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        diff_d = (diff_q >> 1) | dmsb;
        bor_d  = cell_bo;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bout_d  = cell_bo;
          state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into MSB vs borrow out of MSB.
          ovf_d   = bor_q ^ cell_bo;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign diff_out  = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
